// File: rtl/dtc_sm_encoder.sv
// dtc_sm_encoder
// Registered two's-complement to sign-magnitude encoder with valid/ready on
// both sides. The most-negative code can optionally be clamped. When the output
// polarity flips, zero-magnitude guard beats are inserted before the new sign
// so the DTC drive never switches polarity without a break in between.
module dtc_sm_encoder #(
  parameter int WIDTH        = 8,
  parameter int GUARD_CYCLES = 2,
  parameter int SAT_MIN      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dout_sign,
  output logic [WIDTH-1:0] dout_mag,
  output logic             dout_guard,
  output logic             sat_flag
);

  typedef enum logic {
    RUN   = 1'b0,
    GUARD = 1'b1
  } state_t;

  // First guard beat is emitted on the accept itself, so the counter only
  // tracks the remaining ones.
  localparam logic [7:0] GUARD_INIT = (GUARD_CYCLES > 0) ? 8'(GUARD_CYCLES - 1) : 8'd0;
  localparam logic       GUARD_EN   = (GUARD_CYCLES > 0);
  localparam logic       SAT_EN     = (SAT_MIN != 0);

  state_t           state;
  logic [7:0]       cnt;
  logic             last_sign;
  logic             pend_sign;
  logic [WIDTH-1:0] pend_mag;
  logic             pend_sat;

  logic [WIDTH:0]   din_ext;
  logic [WIDTH:0]   din_neg;
  logic [WIDTH:0]   mag_full;
  logic             is_min;
  logic             s_zero;
  logic             s_sign;
  logic             s_sat;
  logic [WIDTH-1:0] s_mag;
  logic             s_flip;
  logic             accept;
  logic             retire;

  // Handshake decode: new samples only enter in RUN when the output slot frees up.
  always_comb begin
    in_ready = (state == RUN) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    retire   = out_valid && out_ready;
  end

  // Magnitude is formed one bit wider so the most-negative code has room;
  // a magnitude of exactly 2^(WIDTH-1) can only come from that code.
  always_comb begin
    din_ext  = {din[WIDTH-1], din};
    din_neg  = -din_ext;
    mag_full = din[WIDTH-1] ? din_neg : din_ext;
    is_min   = (mag_full[WIDTH:WIDTH-1] != 2'b00);
    s_sat    = is_min && SAT_EN;
    s_mag    = s_sat ? {1'b0, {(WIDTH-1){1'b1}}} : mag_full[WIDTH-1:0];
    s_zero   = (din == '0);
    s_sign   = s_zero ? last_sign : ~din[WIDTH-1];
    s_flip   = GUARD_EN && !s_zero && (s_sign != last_sign);
  end

  // Control FSM and output register: direct loads in RUN, guard sequencing in GUARD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= 8'd0;
      last_sign  <= 1'b1;
      pend_sign  <= 1'b1;
      pend_mag   <= '0;
      pend_sat   <= 1'b0;
      out_valid  <= 1'b0;
      dout_sign  <= 1'b1;
      dout_mag   <= '0;
      dout_guard <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            out_valid <= 1'b1;
            if (s_flip) begin
              pend_sign  <= s_sign;
              pend_mag   <= s_mag;
              pend_sat   <= s_sat;
              dout_sign  <= last_sign;
              dout_mag   <= '0;
              dout_guard <= 1'b1;
              sat_flag   <= 1'b0;
              cnt        <= GUARD_INIT;
              state      <= GUARD;
            end else begin
              dout_sign  <= s_sign;
              dout_mag   <= s_mag;
              dout_guard <= 1'b0;
              sat_flag   <= s_sat;
              last_sign  <= s_sign;
            end
          end else if (retire) begin
            out_valid <= 1'b0;
          end
        end
        GUARD: begin
          if (retire) begin
            if (cnt > 8'd0) begin
              dout_sign  <= last_sign;
              dout_mag   <= '0;
              dout_guard <= 1'b1;
              sat_flag   <= 1'b0;
              cnt        <= cnt - 8'd1;
            end else begin
              dout_sign  <= pend_sign;
              dout_mag   <= pend_mag;
              dout_guard <= 1'b0;
              sat_flag   <= pend_sat;
              last_sign  <= pend_sign;
              state      <= RUN;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_sm_encoder.sv
// tb_dtc_sm_encoder
// Three encoder instances: [0] GUARD=2 SAT_MIN=1, [1] GUARD=2 SAT_MIN=0,
// [2] GUARD=0 SAT_MIN=1. Only one instance is driven at a time, so one
// scoreboard queue tagged with the instance index serves all of them.
module tb_dtc_sm_encoder;

  typedef struct {
    int         id;
    logic       sign;
    logic [7:0] mag;
    logic       guard;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [7:0] din [3];
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [2:0] dout_sign;
  logic [7:0] dout_mag [3];
  logic [2:0] dout_guard;
  logic [2:0] sat_flag;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int GC = (i == 2) ? 0 : 2;
    localparam int SM = (i == 1) ? 0 : 1;
    dtc_sm_encoder #(.WIDTH(8), .GUARD_CYCLES(GC), .SAT_MIN(SM)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[i]),
      .in_ready   (in_ready[i]),
      .din        (din[i]),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i]),
      .dout_sign  (dout_sign[i]),
      .dout_mag   (dout_mag[i]),
      .dout_guard (dout_guard[i]),
      .sat_flag   (sat_flag[i])
    );
  end

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pops the expected beat for instance i and compares every output field.
  task automatic checkOutput(input int i);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL beat dut%0d: got unexpected beat sign=%0d mag=%0d guard=%0d sat=%0d, expected none",
               i, dout_sign[i], dout_mag[i], dout_guard[i], sat_flag[i]);
    end else begin
      e = exp_q.pop_front();
      if (e.id != i || dout_sign[i] !== e.sign || dout_mag[i] !== e.mag ||
          dout_guard[i] !== e.guard || sat_flag[i] !== e.sat) begin
        errors++;
        $display("[TB] FAIL beat dut%0d: got sign=%0d mag=%0d guard=%0d sat=%0d, expected dut%0d sign=%0d mag=%0d guard=%0d sat=%0d",
                 i, dout_sign[i], dout_mag[i], dout_guard[i], sat_flag[i],
                 e.id, e.sign, e.mag, e.guard, e.sat);
      end
    end
  endtask

  // Monitor: every retiring beat is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] && out_ready[i]) checkOutput(i);
      end
    end
  end

  task automatic pushExp(input int id, input logic sign, input int mag, input logic guard, input logic sat);
    exp_t e;
    e.id = id; e.sign = sign; e.mag = 8'(mag); e.guard = guard; e.sat = sat;
    exp_q.push_back(e);
  endtask

  // Presents one sample and holds it until accepted; returns 1 ns after the accept edge.
  task automatic applyStimulus(input int id, input int value);
    int waited = 0;
    din[id] = 8'(value);
    in_valid[id] = 1'b1;
    @(negedge clk);
    while (!in_ready[id] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[id]) begin
      checkValue("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid[id] = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    checkValue({name, "_pending_beats"}, exp_q.size(), 0);
  endtask

  task automatic checkResetState(input int i);
    checkValue($sformatf("rst_out_valid%0d", i), int'(out_valid[i]), 0);
    checkValue($sformatf("rst_sign%0d", i), int'(dout_sign[i]), 1);
    checkValue($sformatf("rst_mag%0d", i), int'(dout_mag[i]), 0);
    checkValue($sformatf("rst_guard%0d", i), int'(dout_guard[i]), 0);
    checkValue($sformatf("rst_sat%0d", i), int'(sat_flag[i]), 0);
    checkValue($sformatf("rst_in_ready%0d", i), int'(in_ready[i]), 1);
  endtask

  // Bounds the whole run in case a sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int lows;
    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < 3; i++) din[i] = 8'd0;

    doReset();
    for (int i = 0; i < 3; i++) checkResetState(i);

    $display("[TB] positive stream 5, 100, 0");
    pushExp(0, 1, 5, 0, 0);
    pushExp(0, 1, 100, 0, 0);
    pushExp(0, 1, 0, 0, 0);
    applyStimulus(0, 5);
    checkValue("latency_out_valid", int'(out_valid[0]), 1);
    applyStimulus(0, 100);
    applyStimulus(0, 0);
    drain("stream");

    $display("[TB] flip to -3 then -7");
    doReset();
    pushExp(0, 1, 0, 1, 0);
    pushExp(0, 1, 0, 1, 0);
    pushExp(0, 0, 3, 0, 0);
    pushExp(0, 0, 7, 0, 0);
    applyStimulus(0, -3);
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (in_ready[0]) break;
      lows++;
    end
    checkValue("flip_in_ready_low_cycles", lows, 2);
    @(posedge clk);
    #1;
    applyStimulus(0, -7);
    drain("flip");

    $display("[TB] most-negative code");
    doReset();
    pushExp(0, 1, 0, 1, 0);
    pushExp(0, 1, 0, 1, 0);
    pushExp(0, 0, 127, 0, 1);
    applyStimulus(0, -128);
    drain("sat_min1");
    pushExp(1, 1, 0, 1, 0);
    pushExp(1, 1, 0, 1, 0);
    pushExp(1, 0, 128, 0, 0);
    applyStimulus(1, -128);
    drain("sat_min0");

    $display("[TB] backpressure during first guard beat");
    doReset();
    pushExp(0, 1, 0, 1, 0);
    pushExp(0, 1, 0, 1, 0);
    pushExp(0, 0, 1, 0, 0);
    applyStimulus(0, -1);
    out_ready[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkValue("hold_beat", int'({out_valid[0], dout_sign[0], dout_mag[0], dout_guard[0], sat_flag[0]}),
                 int'({1'b1, 1'b1, 8'd0, 1'b1, 1'b0}));
      checkValue("hold_in_ready", int'(in_ready[0]), 0);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    drain("backpressure");

    $display("[TB] reset during second guard beat");
    doReset();
    pushExp(0, 1, 0, 1, 0);
    applyStimulus(0, -9);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkResetState(0);
    checkValue("rst_scoreboard_empty", exp_q.size(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    pushExp(0, 1, 4, 0, 0);
    applyStimulus(0, 4);
    drain("after_reset");

    $display("[TB] guard disabled 6, -6, 6");
    doReset();
    pushExp(2, 1, 6, 0, 0);
    pushExp(2, 0, 6, 0, 0);
    pushExp(2, 1, 6, 0, 0);
    applyStimulus(2, 6);
    checkValue("noguard_in_ready_a", int'(in_ready[2]), 1);
    applyStimulus(2, -6);
    checkValue("noguard_in_ready_b", int'(in_ready[2]), 1);
    applyStimulus(2, 6);
    checkValue("noguard_in_ready_c", int'(in_ready[2]), 1);
    drain("noguard");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
